// File: rtl/jedro_1_ifu.sv
// rtl/jedro_1_ifu.sv - jedro_1 instruction fetch unit with prefetch FIFO and redirect flush
module jedro_1_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic                  imem_en_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  dec_valid_o,
    input  logic                  dec_ready_i,
    output logic [DATA_WIDTH-1:0] dec_instr_o,
    output logic [ADDR_WIDTH-1:0] dec_pc_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Fetch-side state
    logic                  started_q, started_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;

    // Prefetch FIFO state
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];

    // Handshake / control terms
    logic                  pop;
    logic                  pop_eff;
    logic                  push;
    logic                  req;
    logic [CW-1:0]         occupancy;
    logic [ADDR_WIDTH-1:0] jmp_target;
    logic                  jmp_addr_unused;

    // Byte offset of a redirect target is ignored; fetches are always word aligned.
    assign jmp_target      = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign jmp_addr_unused = ^jmp_addr_i[1:0];

    assign dec_valid_o = (count_q != '0);
    assign pop         = dec_valid_o & dec_ready_i;
    // A redirect discards the head instead of handing it to the decoder.
    assign pop_eff     = pop & ~jmp_instr_i;
    // A response landing in a redirect cycle belongs to the old stream.
    assign push        = inflight_q & ~jmp_instr_i;

    // Slots already promised: buffered words plus the read still in flight,
    // minus whatever leaves this cycle. Requesting only below depth means a
    // response can always be pushed without overflow.
    assign occupancy = count_q + CW'(inflight_q) - CW'(pop);
    assign req       = started_q & ~jmp_instr_i & (occupancy < CW'(FIFO_DEPTH));

    assign imem_en_o   = req;
    assign imem_addr_o = pc_q;

    // Head of the FIFO; forced to zero when nothing is buffered.
    assign dec_instr_o = dec_valid_o ? instr_mem_q[rd_ptr_q] : '0;
    assign dec_pc_o    = dec_valid_o ? pc_mem_q[rd_ptr_q]    : '0;

    // Fetch PC, in-flight flag and response PC next-state
    always_comb begin
        started_d  = 1'b1;
        pc_d       = pc_q;
        inflight_d = req;
        rsp_pc_d   = rsp_pc_q;
        if (jmp_instr_i) begin
            pc_d = jmp_target;
        end else if (req) begin
            pc_d     = pc_q + ADDR_WIDTH'(4);
            rsp_pc_d = pc_q;
        end
    end

    // FIFO pointer and occupancy next-state; a redirect empties the buffer
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (jmp_instr_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop_eff);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            started_q  <= 1'b0;
            pc_q       <= BOOT_ADDR;
            inflight_q <= 1'b0;
            rsp_pc_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            started_q  <= started_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only observed through count, so no reset needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_jedro_1_ifu.sv
// tb/tb_jedro_1_ifu.sv - directed self-checking bench for jedro_1_ifu
module tb_jedro_1_ifu;

    logic        clk;
    logic        rst_n;
    logic        jmp;
    logic [31:0] jaddr;
    logic        en;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;

    logic        rst2_n;
    logic        en2;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] reqs [$];
    bit          seen;

    jedro_1_ifu u_dut (
        .clk_i        (clk),
        .rstn_i       (rst_n),
        .jmp_instr_i  (jmp),
        .jmp_addr_i   (jaddr),
        .imem_en_o    (en),
        .imem_addr_o  (addr),
        .imem_rdata_i (rdata),
        .dec_valid_o  (valid),
        .dec_ready_i  (ready),
        .dec_instr_o  (instr),
        .dec_pc_o     (pc)
    );

    jedro_1_ifu #(.BOOT_ADDR(32'hFFFF_FFF8)) u_dut_wrap (
        .clk_i        (clk),
        .rstn_i       (rst2_n),
        .jmp_instr_i  (1'b0),
        .jmp_addr_i   (32'h0),
        .imem_en_o    (en2),
        .imem_addr_o  (addr2),
        .imem_rdata_i (rdata2),
        .dec_valid_o  (valid2),
        .dec_ready_i  (1'b1),
        .dec_instr_o  (instr2),
        .dec_pc_o     (pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM whose word equals its byte address, one-cycle read latency
    always @(posedge clk) begin
        if (en)  rdata  <= addr;
        if (en2) rdata2 <= addr2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        ready  = 1'b1;
        jmp    = 1'b0;
        jaddr  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_en", {31'b0, en}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);

        // 1: streaming with ready held high
        rst_n = 1'b1;
        #1 chk("t1_en_at_release", {31'b0, en}, 32'h0);
        @(negedge clk);
        chk("t1_first_en", {31'b0, en}, 32'h1);
        chk("t1_first_addr", addr, 32'h0);
        chk("t1_valid_n1", {31'b0, valid}, 32'h0);
        @(negedge clk);
        chk("t1_addr2", addr, 32'h4);
        chk("t1_valid_n2", {31'b0, valid}, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("t1_valid", {31'b0, valid}, 32'h1);
            chk("t1_pc", pc, 32'(4 * k));
            chk("t1_instr", instr, 32'(4 * k));
            @(negedge clk);
        end

        // 2: ready low from reset fills the FIFO with exactly four requests
        rst_n = 1'b0;
        ready = 1'b0;
        #1 chk("t2_valid_in_rst", {31'b0, valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (en) reqs.push_back(addr);
        end
        chk("t2_nreq", 32'(reqs.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_addr", (i < reqs.size()) ? reqs[i] : 32'hDEAD_BEEF, 32'(4 * i));
        end
        chk("t2_full_en", {31'b0, en}, 32'h0);
        chk("t2_hold_valid", {31'b0, valid}, 32'h1);
        chk("t2_hold_pc", pc, 32'h0);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_valid", {31'b0, valid}, 32'h1);
            chk("t2_drain_pc", pc, 32'(4 * i));
            @(negedge clk);
        end

        // 3: redirect while full
        ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_full_en", {31'b0, en}, 32'h0);
        chk("t3_full_valid", {31'b0, valid}, 32'h1);
        jmp   = 1'b1;
        jaddr = 32'h100;
        #1 chk("t3_en_in_j", {31'b0, en}, 32'h0);
        @(negedge clk);
        jmp = 1'b0;
        #1;
        chk("t3_en_j1", {31'b0, en}, 32'h1);
        chk("t3_addr_j1", addr, 32'h100);
        chk("t3_valid_j1", {31'b0, valid}, 32'h0);
        ready = 1'b1;
        @(negedge clk);
        chk("t3_valid_j2", {31'b0, valid}, 32'h0);
        @(negedge clk);
        chk("t3_valid_j3", {31'b0, valid}, 32'h1);
        chk("t3_pc_j3", pc, 32'h100);
        chk("t3_instr_j3", instr, 32'h100);
        @(negedge clk);
        chk("t3_pc_j4", pc, 32'h104);
        @(negedge clk);
        chk("t3_pc_j5", pc, 32'h108);

        // 4: unaligned redirect with a response in flight
        chk("t4_inflight_pre", {31'b0, valid}, 32'h1);
        jmp   = 1'b1;
        jaddr = 32'h103;
        #1 chk("t4_en_in_j", {31'b0, en}, 32'h0);
        @(negedge clk);
        jmp = 1'b0;
        #1;
        chk("t4_addr_j1", addr, 32'h100);
        chk("t4_en_j1", {31'b0, en}, 32'h1);
        chk("t4_valid_j1", {31'b0, valid}, 32'h0);
        @(negedge clk);
        chk("t4_valid_j2", {31'b0, valid}, 32'h0);
        @(negedge clk);
        chk("t4_pc_j3", pc, 32'h100);
        @(negedge clk);
        chk("t4_pc_j4", pc, 32'h104);

        // 5: asynchronous reset with words buffered
        ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_buffered", {31'b0, valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid_async", {31'b0, valid}, 32'h0);
        chk("t5_pc_async", pc, 32'h0);
        chk("t5_instr_async", instr, 32'h0);
        chk("t5_en_async", {31'b0, en}, 32'h0);
        chk("t5_addr_async", addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_resume_en", {31'b0, en}, 32'h1);
        chk("t5_resume_addr", addr, 32'h0);

        // 6: PC wraps past the top of the address space
        rst2_n = 1'b1;
        seen   = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = valid2;
        end
        chk("t6_valid_seen", {31'b0, seen}, 32'h1);
        chk("t6_pc0", pc2, 32'hFFFF_FFF8);
        chk("t6_instr0", instr2, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t6_pc1", pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t6_pc2", pc2, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
